ethernet_tx: RTL and testbench
==============================

# ethernet_tx

MII transmit framer: the transmit counterpart of the team's ethernet_rx block. It takes a byte stream with valid/ready/last handshaking, drives a 4-bit MII transmit bus, and handles preamble/SFD insertion, minimum-length padding, FCS generation and inter-frame gap. It sits between the MAC/packet builder and the PHY's MII TX pins, in the tx_clk domain.

## Interface
- MAX_PACKET_BYTES, 11'd1024: maximum payload bytes accepted per frame, excluding preamble, pad and FCS.
- tx_clk  in  1  MII transmit clock (25 MHz for 100BASE-T); the only clock.
- reset  in  1  synchronous, active-high.
- tx_data  in  8  payload byte.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  marks the final payload byte of the frame.
- tx_ready  out  1  block accepts a byte this cycle (transfer = tx_valid & tx_ready).
- txd  out  4  MII nibble, registered.
- tx_en  out  1  MII transmit enable, registered.
- tx_er  out  1  MII transmit error, registered.
- frame_done  out  1  one-cycle pulse after the last FCS nibble.
- underrun  out  1  one-cycle pulse when the source failed to supply a byte mid-frame.
- oversize  out  1  one-cycle pulse when a frame is truncated at MAX_PACKET_BYTES.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, ABORT, IFG.
- IDLE: tx_ready=1. A transfer loads the hold register and last flag, clears byte count and phase, sets CRC to 0xFFFFFFFF, and goes to PREAMBLE.
- PREAMBLE: 16 nibble cycles. Cycles 0–14 carry 0x5; cycle 15 carries 0xD (SFD 0xD5, low nibble first). Then PAYLOAD.
- PAYLOAD: each byte takes two cycles, low nibble (phase 0) then high nibble (phase 1). The byte counter increments on phase 1.
  - tx_ready=1 only in phase 1, and only if the held byte is not last and the count is below MAX_PACKET_BYTES−1.
  - Transfer in phase 1: load the next byte and continue.
  - tx_ready=1 but tx_valid=0: go to ABORT and pulse underrun.
  - Held byte last, or count reaches MAX_PACKET_BYTES: leave after its phase 1. If count < 60, go to PAD; otherwise go to FCS.
  - The MAX_PACKET_BYTES-th byte is treated as last even without tx_last, and oversize pulses.
- PAD: send zero bytes (two 0x0 nibbles each) until the byte count reaches 60, then FCS.
- CRC: reflected CRC-32, polynomial 0xEDB88320, updated per nibble (LSB first) over every payload and pad nibble.
- FCS: 8 cycles, sending ~crc[3:0], ~crc[7:4], … ~crc[31:28]. frame_done pulses the cycle after the 8th nibble. Then IFG.
- ABORT: 2 cycles with tx_en=1, tx_er=1, txd=0x0, then IFG. No FCS is sent.
- IFG: 24 cycles with tx_en=0 and tx_ready=0, then IDLE.
- Reset in any state: go to IDLE next edge. Reset values: txd=0, tx_en=0, tx_er=0, frame_done=0, underrun=0, oversize=0. tx_ready=0 while reset is high.

## Timing
- Transfer in IDLE at edge T: tx_en=1 with txd=0x5 from edge T+1.
- Frame length on the wire is 16 + 2·max(N,60) + 8 cycles of tx_en for N payload bytes.
- Back-to-back frames: the next IDLE transfer is possible on the first cycle after IFG. Minimum gap is 24 cycles of tx_en=0.
- txd, tx_en and tx_er change only on tx_clk edges. tx_ready is decoded from state and phase; it does not depend on tx_valid.
- Byte counter width: $clog2(MAX_PACKET_BYTES)+1 bits; no wrap is possible because of the MAX check.

## Structure
- Shared package ethernet_pkg:
  - state_t enum
  - PREAMBLE_NIBBLES=16
  - SFD=8'hD5
  - MIN_PAYLOAD_BYTES=60
  - IFG_NIBBLES=24
  - CRC32_POLY=32'hEDB88320
  - CRC32_RESIDUE=32'hDEBB20E3
- Sub-module crc32_nibble: combinational next-CRC from current CRC and a 4-bit data nibble. It is reused later by ethernet_rx for FCS checking.
- The FSM, hold register, phase bit, byte counter and cycle counter live in ethernet_tx.

## Test plan
- 60-byte frame, bytes 0x00..0x3B, tx_valid held high:
  - wire shows 15×0x5, then 0xD, then nibbles 0x0,0x0,0x1,0x0,…, with no pad;
  - 8 FCS nibbles follow;
  - running the receiver-side CRC over payload+FCS gives register 0xDEBB20E3;
  - tx_en is high for exactly 144 cycles and frame_done pulses once.
- 1-byte frame 0xAB with tx_last:
  - payload nibbles are 0xB, 0xA, followed by 118 zero nibbles;
  - the FCS is valid (residue 0xDEBB20E3) and tx_en is high for 144 cycles.
- Underrun:
  - a 100-byte frame with tx_valid dropped during the phase-1 cycle of byte 10;
  - expect 2 cycles of tx_en=1, tx_er=1, txd=0, then one underrun pulse, then tx_en=0 for 24 cycles.
- Oversize:
  - MAX_PACKET_BYTES=64 and 80 bytes offered with no tx_last;
  - expect 64 bytes accepted, then FCS, then one oversize pulse, and tx_ready=0 from byte 64 until IFG ends.
- Back-to-back:
  - two 60-byte frames offered continuously;
  - expect exactly 24 cycles of tx_en=0 between them, and the second transfer on the first IDLE cycle.
- Reset mid-frame:
  - reset asserted for 1 cycle during PAYLOAD;
  - expect txd=0 and tx_en=0 on the next edge, tx_ready=1 the cycle after reset deasserts, and a new frame that is correct from its preamble.

Source files
------------

// File: rtl/ethernet_pkg.sv
// ethernet_pkg: states and framing constants shared by the MII transmit and receive paths
package ethernet_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PAD, S_FCS, S_ABORT, S_IFG} state_t;
  localparam int PREAMBLE_NIBBLES = 16;
  localparam logic [7:0] SFD = 8'hD5;
  localparam int MIN_PAYLOAD_BYTES = 60;
  localparam int IFG_NIBBLES = 24;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
endpackage

// File: rtl/crc32_nibble.sv
// crc32_nibble: next reflected CRC-32 register after absorbing one nibble, LSB first
module crc32_nibble
  import ethernet_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_nib,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 4; i++) o_crc = (o_crc[0] ^ i_nib[i]) ? (o_crc >> 1) ^ CRC32_POLY : o_crc >> 1;
  end
endmodule

// File: rtl/ethernet_tx.sv
// ethernet_tx: MII transmit framer with preamble, padding, FCS and inter-frame gap
module ethernet_tx
  import ethernet_pkg::*;
#(
  parameter logic [10:0] MAX_PACKET_BYTES = 11'd1024
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       frame_done,
  output logic       underrun,
  output logic       oversize
);
  localparam int CW = $clog2(MAX_PACKET_BYTES) + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_PACKET_BYTES);
  localparam logic [CW-1:0] MINC = CW'(MIN_PAYLOAD_BYTES);
  state_t        r_state;
  logic [7:0]    r_hold;
  logic          r_last, r_phase, r_fin, r_trunc;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_cyc;
  logic [31:0]   r_crc;
  logic [3:0]    w_nib;
  logic [31:0]   w_crc;
  logic [CW-1:0] w_cnt;
  logic          w_max;
  assign w_nib = (r_state == S_PAD) ? 4'h0 : (r_phase ? r_hold[7:4] : r_hold[3:0]);
  assign w_cnt = r_cnt + 1'b1;
  assign w_max = w_cnt == MAXC;
  assign tx_ready = !reset && (r_state == S_IDLE || (r_state == S_PAYLOAD && r_phase && !r_last && !w_max));
  crc32_nibble u_crc (.i_crc(r_crc), .i_nib(w_nib), .o_crc(w_crc));
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cyc <= '0;
      txd <= '0;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      oversize <= 1'b0;
    end else begin
      txd <= '0;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      oversize <= 1'b0;
      r_cyc <= r_cyc + 1'b1;
      case (r_state)
        S_IDLE: if (tx_valid) begin
          r_hold <= tx_data;
          r_last <= tx_last;
          r_cnt <= '0;
          r_phase <= 1'b0;
          r_crc <= '1;
          r_cyc <= '0;
          r_trunc <= 1'b0;
          r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          tx_en <= 1'b1;
          txd <= (r_cyc == 5'(PREAMBLE_NIBBLES - 1)) ? SFD[7:4] : 4'h5;
          if (r_cyc == 5'(PREAMBLE_NIBBLES - 1)) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD, S_PAD: begin
          tx_en <= 1'b1;
          txd <= w_nib;
          r_crc <= w_crc;
          r_phase <= !r_phase;
          if (r_phase) begin
            r_cnt <= w_cnt;
            if (r_state == S_PAD || r_last || w_max) begin
              r_state <= (w_cnt < MINC) ? S_PAD : S_FCS;
              r_cyc <= '0;
              r_trunc <= r_trunc | (r_state == S_PAYLOAD && w_max && !r_last);
            end else if (tx_valid) begin
              r_hold <= tx_data;
              r_last <= tx_last;
            end else begin
              r_state <= S_ABORT;
              r_cyc <= '0;
            end
          end
        end
        S_FCS: begin
          tx_en <= 1'b1;
          txd <= ~r_crc[{r_cyc[2:0], 2'b00} +: 4];
          if (r_cyc == 5'd7) begin
            r_state <= S_IFG;
            r_cyc <= '0;
            r_fin <= 1'b1;
          end
        end
        S_ABORT: begin
          tx_en <= 1'b1;
          tx_er <= 1'b1;
          if (r_cyc == 5'd1) begin
            r_state <= S_IFG;
            r_cyc <= '0;
            r_fin <= 1'b0;
          end
        end
        S_IFG: begin
          frame_done <= r_cyc == '0 && r_fin;
          oversize <= r_cyc == '0 && r_fin && r_trunc;
          underrun <= r_cyc == '0 && !r_fin;
          // the IDLE cycle that follows completes the gap
          if (r_cyc == 5'(IFG_NIBBLES - 2)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_tx.sv
// tb_ethernet_tx: directed and randomized frames checked against a byte-level framing and CRC model
module tb_ethernet_tx;
  import ethernet_pkg::*;
  typedef logic [7:0] byte_q[$];
  typedef logic [3:0] nib_q[$];
  typedef bit bit_q[$];
  logic clk = 0, reset = 1, sel = 0, valid = 0, last = 0;
  logic [7:0] data = 0;
  logic valid_a, valid_b, ready_a, ready_b, en_a, en_b, er_a, er_b, done_a, done_b, und_a, und_b, ovs_a, ovs_b;
  logic [3:0] txd_a, txd_b;
  logic s_ready, s_en, s_er, s_done, s_und, s_ovs;
  logic [3:0] s_txd;
  int errors = 0, checks = 0;
  nib_q txd_l;
  bit_q en_l, er_l, done_l, und_l, ovs_l, rdy_l;
  int acc_l[$];
  always #5 clk = ~clk;
  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign s_ready = sel ? ready_b : ready_a;
  assign s_txd = sel ? txd_b : txd_a;
  assign s_en = sel ? en_b : en_a;
  assign s_er = sel ? er_b : er_a;
  assign s_done = sel ? done_b : done_a;
  assign s_und = sel ? und_b : und_a;
  assign s_ovs = sel ? ovs_b : ovs_a;
  ethernet_tx u_dut (.tx_clk(clk), .reset(reset), .tx_data(data), .tx_valid(valid_a), .tx_last(last),
    .tx_ready(ready_a), .txd(txd_a), .tx_en(en_a), .tx_er(er_a), .frame_done(done_a), .underrun(und_a), .oversize(ovs_a));
  ethernet_tx #(.MAX_PACKET_BYTES(11'd64)) u_ovs (.tx_clk(clk), .reset(reset), .tx_data(data), .tx_valid(valid_b), .tx_last(last),
    .tx_ready(ready_b), .txd(txd_b), .tx_en(en_b), .tx_er(er_b), .frame_done(done_b), .underrun(und_b), .oversize(ovs_b));

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_bytes(byte_q q);
    logic [31:0] c = '1;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      repeat (8) c = c[0] ? (c >> 1) ^ CRC32_POLY : c >> 1;
    end
    return c;
  endfunction

  function automatic nib_q build(byte_q p);
    byte_q b = p;
    nib_q n;
    logic [31:0] f;
    while (b.size() < MIN_PAYLOAD_BYTES) b.push_back(8'h00);
    f = ~crc_bytes(b);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    repeat (15) n.push_back(4'h5);
    n.push_back(4'hD);
    foreach (b[i]) begin
      n.push_back(b[i][3:0]);
      n.push_back(b[i][7:4]);
    end
    return n;
  endfunction

  function automatic logic [31:0] residue(nib_q n);
    byte_q b;
    for (int i = 16; i + 1 < n.size(); i += 2) b.push_back({n[i+1], n[i]});
    return crc_bytes(b);
  endfunction

  function automatic int diff(nib_q a, nib_q b);
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
  endfunction

  function automatic int first(bit_q q, int from, bit v);
    if (from < 0) return -1;
    for (int i = from; i < q.size(); i++) if (q[i] == v) return i;
    return -1;
  endfunction

  function automatic int count(bit_q q, int lo, int hi);
    int n = 0;
    for (int i = (lo < 0 ? 0 : lo); i < hi && i < q.size(); i++) n += q[i];
    return n;
  endfunction

  function automatic nib_q captured();
    nib_q n;
    foreach (txd_l[i]) if (en_l[i] && !er_l[i]) n.push_back(txd_l[i]);
    return n;
  endfunction

  task automatic present(byte_q d, bit_q l, int idx, int drop_at);
    valid = idx < d.size() && idx != drop_at;
    data = 8'h00;
    last = 1'b0;
    if (valid) begin
      data = d[idx];
      last = l[idx];
    end
  endtask

  // source honours valid/ready; every sample is logged 1 time unit after the edge
  task automatic run(byte_q d, bit_q l, int drop_at, int ncyc);
    int idx = 0, acc = 0;
    txd_l = {}; en_l = {}; er_l = {}; done_l = {}; und_l = {}; ovs_l = {}; rdy_l = {}; acc_l = {};
    present(d, l, idx, drop_at);
    for (int c = 0; c < ncyc; c++) begin
      bit x;
      x = valid & s_ready;
      @(posedge clk);
      #1;
      if (x) begin
        idx++;
        acc++;
      end
      txd_l.push_back(s_txd); en_l.push_back(s_en); er_l.push_back(s_er); done_l.push_back(s_done);
      und_l.push_back(s_und); ovs_l.push_back(s_ovs); rdy_l.push_back(s_ready); acc_l.push_back(acc);
      present(d, l, idx, drop_at);
    end
    valid = 0;
    last = 0;
  endtask

  task automatic verify_frame(string t, byte_q d);
    nib_q exp = build(d);
    nib_q got = captured();
    int m = d.size() < MIN_PAYLOAD_BYTES ? MIN_PAYLOAD_BYTES : d.size();
    int f = first(en_l, first(en_l, 0, 1), 0);
    check({t, "_len"}, got.size(), exp.size());
    check({t, "_first_diff"}, diff(got, exp), -1);
    check({t, "_residue"}, residue(got), CRC32_RESIDUE);
    check({t, "_en_cycles"}, count(en_l, 0, en_l.size()), 16 + 2 * m + 8);
    check({t, "_done_count"}, count(done_l, 0, done_l.size()), 1);
    check({t, "_done_pos"}, first(done_l, 0, 1), f);
    check({t, "_er_count"}, count(er_l, 0, er_l.size()), 0);
    check({t, "_underrun_count"}, count(und_l, 0, und_l.size()), 0);
  endtask

  task automatic single(string t, byte_q d);
    bit_q l;
    foreach (d[i]) l.push_back(i == d.size() - 1);
    run(d, l, -1, 2 * (d.size() < 60 ? 60 : d.size()) + 80);
    verify_frame(t, d);
  endtask

  initial begin
    byte_q d, f2;
    bit_q l;
    nib_q exp, got;
    int e, f, s2, i64;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd_a, 0);
    check("reset_en", en_a, 0);
    check("reset_er", er_a, 0);
    check("reset_done", done_a, 0);
    check("reset_ready", ready_a, 0);
    reset = 0;
    #1;
    check("idle_ready", ready_a, 1);
    d = {};
    for (int i = 0; i < 60; i++) d.push_back(8'(i));
    single("ramp60", d);
    d = {8'hAB};
    single("one_byte", d);
    for (int k = 0; k < 3; k++) begin
      d = {};
      repeat ($urandom_range(1, 140)) d.push_back(8'($urandom));
      single($sformatf("rand%0d", k), d);
    end
    // underrun: source goes quiet while byte 10 is held
    d = {}; l = {};
    repeat (100) begin d.push_back(8'($urandom)); l.push_back(0); end
    run(d, l, 11, 120);
    e = first(er_l, 0, 1);
    exp = build(d);
    got = captured();
    check("urun_er_start", e, 16 + 2 * 11 + 1);
    check("urun_er_count", count(er_l, 0, er_l.size()), 2);
    check("urun_er_zero_txd", (e >= 0) ? ((en_l[e] && en_l[e+1] && txd_l[e] == 0 && txd_l[e+1] == 0) ? 1 : 0) : 0, 1);
    check("urun_pulse_count", count(und_l, 0, und_l.size()), 1);
    check("urun_pulse_pos", first(und_l, 0, 1), e + 2);
    check("urun_gap_en", count(en_l, e + 2, e + 26), 0);
    check("urun_done_count", count(done_l, 0, done_l.size()), 0);
    check("urun_prefix_len", got.size(), 38);
    check("urun_prefix_diff", diff(got, exp[0:37]), -1);
    // back-to-back
    d = {}; f2 = {}; l = {};
    for (int i = 0; i < 120; i++) begin
      d.push_back(8'($urandom));
      l.push_back(i == 59 || i == 119);
      if (i >= 60) f2.push_back(d[i]);
    end
    run(d, l, -1, 400);
    exp = build(d[0:59]);
    exp = {exp, build(f2)};
    f = first(en_l, first(en_l, 0, 1), 0);
    s2 = first(en_l, f, 1);
    check("b2b_diff", diff(captured(), exp), -1);
    check("b2b_gap", s2 - f, 24);
    check("b2b_done_count", count(done_l, 0, done_l.size()), 2);
    check("b2b_first_idle_ready", (f >= 0) ? {rdy_l[f+21], rdy_l[f+22]} : 0, 2'b01);
    // oversize on the 64-byte instance
    sel = 1;
    d = {}; l = {};
    repeat (80) begin d.push_back(8'($urandom)); l.push_back(0); end
    run(d, l, -1, 177);
    f = first(done_l, 0, 1);
    i64 = -1;
    foreach (acc_l[i]) if (i64 < 0 && acc_l[i] == 64) i64 = i;
    check("ovs_diff", diff(captured(), build(d[0:63])), -1);
    check("ovs_done_pos", f, 25 + 128);
    check("ovs_pulse_count", count(ovs_l, 0, ovs_l.size()), 1);
    check("ovs_pulse_pos", first(ovs_l, 0, 1), f);
    check("ovs_accepted", (f >= 0) ? acc_l[f] : -1, 64);
    check("ovs_ready_low", count(rdy_l, i64, f + 22), 0);
    check("ovs_ready_after_ifg", (f >= 0) ? rdy_l[f+22] : 0, 1);
    sel = 0;
    // reset mid-frame
    d = {}; l = {};
    for (int i = 0; i < 80; i++) begin d.push_back(8'($urandom)); l.push_back(i == 79); end
    run(d, l, -1, 40);
    check("rst_pre_en", en_a, 1);
    reset = 1;
    #1;
    check("rst_ready_low", ready_a, 0);
    @(posedge clk);
    #1;
    check("rst_txd", txd_a, 0);
    check("rst_en", en_a, 0);
    reset = 0;
    #1;
    check("rst_ready_high", ready_a, 1);
    d = {};
    repeat (70) d.push_back(8'($urandom));
    single("after_rst", d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
